// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared chain geometry helpers and scan mode encoding
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_CAPTURE = 2'd0,
        MODE_HOLD    = 2'd1,
        MODE_SHIFT   = 2'd2
    } scan_mode_e;

    // Guarded against a zero chain count so the bad-parameter check can report cleanly.
    function automatic int chain_len(input int width, input int num_chains);
        return (num_chains > 0) ? width / num_chains : 1;
    endfunction

    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

    function automatic scan_mode_e decode_mode(input logic scan_enable, input logic hold);
        if (scan_enable) begin
            return MODE_SHIFT;
        end else if (hold) begin
            return MODE_HOLD;
        end
        return MODE_CAPTURE;
    endfunction

endpackage

// File: rtl/scan_chain_seg.sv
// rtl/scan_chain_seg.sv - one L-bit shift/hold/capture scan chain segment
module scan_chain_seg
    import scan_pkg::*;
#(
    parameter int             L       = 4,
    parameter logic [L-1:0]   RST_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  scan_mode_e mode,
    input  logic [L-1:0] d,
    input  logic       scan_in,
    output logic [L-1:0] q,
    output logic       scan_out
);

    logic [L-1:0] shifted;

    // Single-bit chains have no upper slice to carry, so the shift is just the serial input.
    generate
        if (L == 1) begin : g_one
            assign shifted = scan_in;
        end else begin : g_multi
            assign shifted = {q[L-2:0], scan_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            case (mode)
                MODE_SHIFT: q <= shifted;
                MODE_HOLD:  q <= q;
                default:    q <= d;
            endcase
        end
    end

    assign scan_out = q[L-1];

endmodule

// File: rtl/scan_reg_bank.sv
// rtl/scan_reg_bank.sv - WIDTH-bit scan register bank split into NUM_CHAINS chains with load counter
module scan_reg_bank
    import scan_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               NUM_CHAINS = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    localparam int              L          = chain_len(WIDTH, NUM_CHAINS),
    localparam int              CW         = cnt_width(L)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      d,
    input  logic                  scan_enable,
    input  logic                  hold,
    input  logic [NUM_CHAINS-1:0] scan_in,
    output logic [WIDTH-1:0]      q,
    output logic [NUM_CHAINS-1:0] scan_out,
    output logic [CW-1:0]         shift_cnt,
    output logic                  shift_done
);

    generate
        if (NUM_CHAINS < 1 || NUM_CHAINS > WIDTH || (WIDTH % NUM_CHAINS) != 0) begin : g_bad_params
            $error("scan_reg_bank: WIDTH must be a multiple of NUM_CHAINS and NUM_CHAINS in 1..WIDTH");
        end
    endgenerate

    localparam logic [CW-1:0] L_CNT = CW'(L);

    scan_mode_e mode;

    always_comb begin
        mode = decode_mode(scan_enable, hold);
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        scan_chain_seg #(
            .L       (L),
            .RST_VAL (RST_VAL[c*L +: L])
        ) u_seg (
            .clk      (clk),
            .rst      (rst),
            .mode     (mode),
            .d        (d[c*L +: L]),
            .scan_in  (scan_in[c]),
            .q        (q[c*L +: L]),
            .scan_out (scan_out[c])
        );
    end

    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = (shift_cnt == L_CNT) ? CW'(1) : shift_cnt + CW'(1);
    end

    // Any non-shift edge abandons a partial load, so the count and pulse clear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt  <= '0;
            shift_done <= 1'b0;
        end else if (scan_enable) begin
            shift_cnt  <= cnt_next;
            shift_done <= (cnt_next == L_CNT);
        end else begin
            shift_cnt  <= '0;
            shift_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_reg_bank.sv
// tb/tb_scan_reg_bank.sv - scoreboard bench for scan_reg_bank with WIDTH=8, NUM_CHAINS=2
module tb_scan_reg_bank;
    import scan_pkg::*;

    localparam int         WIDTH      = 8;
    localparam int         NUM_CHAINS = 2;
    localparam logic [7:0] RV         = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d = 8'h00;
    logic       scan_enable = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] scan_in = 2'b00;
    logic [7:0] q;
    logic [1:0] scan_out;
    logic [2:0] shift_cnt;
    logic       shift_done;

    scan_reg_bank #(
        .WIDTH      (WIDTH),
        .NUM_CHAINS (NUM_CHAINS),
        .RST_VAL    (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d           (d),
        .scan_enable (scan_enable),
        .hold        (hold),
        .scan_in     (scan_in),
        .q           (q),
        .scan_out    (scan_out),
        .shift_cnt   (shift_cnt),
        .shift_done  (shift_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        scan_mode_e mode;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Drive on the falling edge and queue what the following rising edge must produce.
    task automatic step(input string name, input logic r, input logic se, input logic hd,
                        input logic [1:0] si, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [2:0] ec, input logic ed);
        exp_t e;
        @(negedge clk);
        rst         = r;
        scan_enable = se;
        hold        = hd;
        scan_in     = si;
        d           = dv;
        e.name = name;
        e.mode = decode_mode(se, hd);
        e.q    = eq;
        e.cnt  = ec;
        e.done = ed;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, "/", e.mode.name()}, "q", q, e.q);
                chk({e.name, "/", e.mode.name()}, "scan_out", {6'd0, scan_out}, {6'd0, e.q[7], e.q[3]});
                chk({e.name, "/", e.mode.name()}, "shift_cnt", {5'd0, shift_cnt}, {5'd0, e.cnt});
                chk({e.name, "/", e.mode.name()}, "shift_done", {7'd0, shift_done}, {7'd0, e.done});
            end
        end
    end

    initial begin : driver
        //     name        rst se  hd  si     d      q      cnt done
        step("reset",      1, 0, 0, 2'b00, 8'hFF, 8'hA5, 0, 0);
        step("capture",    0, 0, 0, 2'b00, 8'h3C, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++)
            step("hold",   0, 0, 1, 2'b00, 8'hC3, 8'h3C, 0, 0);

        step("load1",      0, 1, 0, 2'b01, 8'h00, 8'h69, 1, 0);
        step("load2",      0, 1, 0, 2'b00, 8'h00, 8'hC2, 2, 0);
        step("load3",      0, 1, 0, 2'b11, 8'h00, 8'h95, 3, 0);
        step("load4",      0, 1, 0, 2'b01, 8'h00, 8'h2B, 4, 1);
        step("load_after", 0, 0, 1, 2'b00, 8'h00, 8'h2B, 0, 0);

        step("preload",    0, 0, 0, 2'b00, 8'h81, 8'h81, 0, 0);
        step("unload1",    0, 1, 0, 2'b00, 8'h00, 8'h02, 1, 0);
        step("unload2",    0, 1, 0, 2'b00, 8'h00, 8'h04, 2, 0);
        step("unload3",    0, 1, 0, 2'b00, 8'h00, 8'h08, 3, 0);
        step("unload4",    0, 1, 0, 2'b00, 8'h00, 8'h00, 4, 1);

        step("abort_s1",   0, 1, 1, 2'b11, 8'h00, 8'h11, 1, 0);
        step("abort_s2",   0, 1, 0, 2'b11, 8'h00, 8'h33, 2, 0);
        step("abort_gap",  0, 0, 1, 2'b00, 8'h5A, 8'h33, 0, 0);
        step("abort_r1",   0, 1, 0, 2'b00, 8'h00, 8'h66, 1, 0);
        step("abort_r2",   0, 1, 0, 2'b00, 8'h00, 8'hCC, 2, 0);
        step("abort_r3",   0, 1, 0, 2'b00, 8'h00, 8'h88, 3, 0);
        step("abort_r4",   0, 1, 0, 2'b00, 8'h00, 8'h00, 4, 1);
        step("abort_idle", 0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 0);

        step("late_s1",    0, 1, 0, 2'b00, 8'h00, 8'h00, 1, 0);
        step("late_s2",    0, 1, 0, 2'b00, 8'h00, 8'h00, 2, 0);
        step("late_s3",    0, 1, 0, 2'b00, 8'h00, 8'h00, 3, 0);
        step("late_cap",   0, 0, 0, 2'b00, 8'h5A, 8'h5A, 0, 0);

        step("rmid_s1",    0, 1, 0, 2'b01, 8'h00, 8'hA5, 1, 0);
        step("rmid_s2",    0, 1, 0, 2'b01, 8'h00, 8'h4B, 2, 0);
        step("rmid_s3",    0, 1, 0, 2'b01, 8'h00, 8'h87, 3, 0);
        step("rmid_rst",   1, 1, 0, 2'b11, 8'h00, 8'hA5, 0, 0);
        step("clean1",     0, 1, 0, 2'b11, 8'h00, 8'h5B, 1, 0);
        step("clean2",     0, 1, 0, 2'b11, 8'h00, 8'hB7, 2, 0);
        step("clean3",     0, 1, 0, 2'b11, 8'h00, 8'h7F, 3, 0);
        step("clean4",     0, 1, 0, 2'b11, 8'h00, 8'hFF, 4, 1);

        step("b2b1",       0, 1, 0, 2'b00, 8'h00, 8'hEE, 1, 0);
        step("b2b2",       0, 1, 0, 2'b00, 8'h00, 8'hCC, 2, 0);
        step("b2b3",       0, 1, 0, 2'b00, 8'h00, 8'h88, 3, 0);
        step("b2b4",       0, 1, 0, 2'b00, 8'h00, 8'h00, 4, 1);
        step("b2b_idle",   0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
